// File: rtl/criq_reclaim.sv
// criq_reclaim: collects physical tags released by two retire slots into a
// small circular staging FIFO and drains them one per cycle into the
// free-list queue. Tag 0 (architectural zero register) is never recycled.
// A pipeline flush empties the staging buffer and parks the block in FLUSH
// until the flush signal drops.
module criq_reclaim #(
    parameter int CRIQWIDE  = 5,
    parameter int STAGEDEEP = 4
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                RetireValid0,
    input  logic [CRIQWIDE-1:0] RetireTag0,
    input  logic                RetireValid1,
    input  logic [CRIQWIDE-1:0] RetireTag1,
    output logic                RetireReady,
    input  logic                CriqClean,
    input  logic                CriqFull,
    output logic                Wable,
    output logic [CRIQWIDE-1:0] Din,
    output logic [2:0]          StageCount,
    output logic [15:0]         ReclaimCnt,
    output logic                ErrOverflow
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]          r_state;
    logic [1:0]          r_head;
    logic [1:0]          r_tail;
    logic [2:0]          r_count;
    logic [15:0]         r_reclaimCnt;
    logic                r_errOverflow;
    logic [CRIQWIDE-1:0] r_stage [STAGEDEEP];

    logic                w_run;
    logic                w_push0;
    logic                w_push1;
    logic [1:0]          w_pushes;
    logic [1:0]          w_tail1;
    logic                w_pop;

    // Handshake, push qualification and drain decode. A flush seen in RUN
    // suppresses both the write strobe and any pushes in that same cycle.
    always_comb begin
        w_run       = (r_state == RUN);
        RetireReady = (r_count <= 3'd2) && w_run;
        w_push0     = RetireReady && !CriqClean && RetireValid0 && (RetireTag0 != '0);
        w_push1     = RetireReady && !CriqClean && RetireValid1 && (RetireTag1 != '0);
        w_pushes    = {1'b0, w_push0} + {1'b0, w_push1};
        w_tail1     = w_push0 ? (r_tail + 2'd1) : r_tail;
        w_pop       = (r_count != 3'd0) && !CriqFull && w_run && !CriqClean;
        Wable       = w_pop;
        Din         = (r_count != 3'd0) ? r_stage[r_head] : '0;
        StageCount  = r_count;
        ReclaimCnt  = r_reclaimCnt;
        ErrOverflow = r_errOverflow;
    end

    // Two-state flush controller: stay in FLUSH for as long as the flush holds.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (CriqClean)  r_state <= FLUSH;
                FLUSH:   if (!CriqClean) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // Staging pointers and occupancy; a flush drops everything staged.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else if (CriqClean) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            r_head  <= r_head + {1'b0, w_pop};
            r_tail  <= r_tail + w_pushes;
            r_count <= r_count + {1'b0, w_pushes} - {2'b00, w_pop};
        end
    end

    // Staging storage; slot 0 lands ahead of slot 1 to keep retire order.
    always_ff @(posedge Clk) begin
        if (w_push0) r_stage[r_tail]  <= RetireTag0;
        if (w_push1) r_stage[w_tail1] <= RetireTag1;
    end

    // Free-list write counter, wrapping naturally at 16 bits.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_reclaimCnt <= 16'd0;
        end else if (w_pop) begin
            r_reclaimCnt <= r_reclaimCnt + 16'd1;
        end
    end

    // Sticky overflow: any valid slot offered while not ready was lost.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_errOverflow <= 1'b0;
        end else if (!RetireReady && (RetireValid0 || RetireValid1)) begin
            r_errOverflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_criq_reclaim.sv
// tb_criq_reclaim: directed scoreboard bench for criq_reclaim. Accepted tags
// are queued in order as they are offered; a negedge monitor pops and compares
// on every write strobe.
module tb_criq_reclaim;

    logic        Clk;
    logic        Rest;
    logic        RetireValid0;
    logic [4:0]  RetireTag0;
    logic        RetireValid1;
    logic [4:0]  RetireTag1;
    logic        RetireReady;
    logic        CriqClean;
    logic        CriqFull;
    logic        Wable;
    logic [4:0]  Din;
    logic [2:0]  StageCount;
    logic [15:0] ReclaimCnt;
    logic        ErrOverflow;

    int          tests;
    int          fails;
    int          expRecl;
    int          tagNext;
    logic [4:0]  expQ[$];

    criq_reclaim #(.CRIQWIDE(5), .STAGEDEEP(4)) dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .RetireValid0 (RetireValid0),
        .RetireTag0   (RetireTag0),
        .RetireValid1 (RetireValid1),
        .RetireTag1   (RetireTag1),
        .RetireReady  (RetireReady),
        .CriqClean    (CriqClean),
        .CriqFull     (CriqFull),
        .Wable        (Wable),
        .Din          (Din),
        .StageCount   (StageCount),
        .ReclaimCnt   (ReclaimCnt),
        .ErrOverflow  (ErrOverflow)
    );

    // Free-running 10-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Write monitor: every strobe must deliver the oldest outstanding tag.
    always @(negedge Clk) begin
        if (Rest === 1'b1 && Wable === 1'b1) begin
            logic [4:0] expTag;
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL wablePulse: got write Din=%0d, required no write", Din);
            end else begin
                expTag = expQ.pop_front();
                if (Din !== expTag) begin
                    fails++;
                    $display("[TB] FAIL dinOrder: got Din=%0d, required %0d", Din, expTag);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive both retire slots; when the bench expects acceptance, record the
    // nonzero tags in slot order as future free-list writes.
    task automatic applyStimulus(input logic v0, input logic [4:0] t0,
                                 input logic v1, input logic [4:0] t1,
                                 input logic expectAccept);
        RetireValid0 = v0;
        RetireTag0   = t0;
        RetireValid1 = v1;
        RetireTag1   = t1;
        if (expectAccept) begin
            if (v0 && t0 != 5'd0) begin expQ.push_back(t0); expRecl++; end
            if (v1 && t1 != 5'd0) begin expQ.push_back(t1); expRecl++; end
        end
    endtask

    task automatic drain();
        int n;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        CriqFull = 1'b0;
        n = 0;
        while (StageCount != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drainEmpty", {13'd0, StageCount}, 16'd0);
        checkOutput("reclaimCnt", ReclaimCnt, expRecl[15:0]);
    endtask

    task automatic resetDut();
        Rest      = 1'b0;
        CriqClean = 1'b0;
        CriqFull  = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expQ.delete();
        expRecl = 0;
        tick();
        tick();
        checkOutput("rstWable", {15'd0, Wable}, 16'd0);
        checkOutput("rstDin", {11'd0, Din}, 16'd0);
        checkOutput("rstReady", {15'd0, RetireReady}, 16'd1);
        checkOutput("rstCount", {13'd0, StageCount}, 16'd0);
        checkOutput("rstReclaim", ReclaimCnt, 16'd0);
        checkOutput("rstErr", {15'd0, ErrOverflow}, 16'd0);
        #2;
        Rest = 1'b1;
        tick();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        tagNext = 1;
        resetDut();

        // Two tags in one cycle leave on consecutive cycles, slot 0 first.
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd11, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("pairCount", {13'd0, StageCount}, 16'd2);
        checkOutput("pairWable", {15'd0, Wable}, 16'd1);
        tick();
        checkOutput("pairCount1", {13'd0, StageCount}, 16'd1);
        tick();
        checkOutput("pairReclaim", ReclaimCnt, 16'd2);

        // Tag 0 is never staged.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("zeroTagCount", {13'd0, StageCount}, 16'd1);
        tick();
        checkOutput("zeroTagReclaim", ReclaimCnt, 16'd3);

        // Back-to-back pairs, offered only while ready: never drops.
        for (int i = 0; i < 12; i++) begin
            if (RetireReady) begin
                applyStimulus(1'b1, tagNext[4:0], 1'b1, tagNext[4:0] + 5'd1, 1'b1);
                tagNext += 2;
            end else begin
                applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            end
            tick();
            checkOutput("steadyInRange",
                        {15'd0, (StageCount == 3'd2) || (StageCount == 3'd3)}, 16'd1);
        end
        checkOutput("steadyNoErr", {15'd0, ErrOverflow}, 16'd0);
        drain();

        // Back-pressure: hold while full, overflow on a refused offer.
        resetDut();
        CriqFull = 1'b1;
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd7, 1'b1);
        tick();
        checkOutput("fullReady2", {15'd0, RetireReady}, 16'd1);
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("fullCount3", {13'd0, StageCount}, 16'd3);
        checkOutput("fullReady3", {15'd0, RetireReady}, 16'd0);
        checkOutput("fullErrClear", {15'd0, ErrOverflow}, 16'd0);
        applyStimulus(1'b1, 5'd13, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("overflowSet", {15'd0, ErrOverflow}, 16'd1);
        checkOutput("overflowCount", {13'd0, StageCount}, 16'd3);
        drain();

        // Flush with three staged tags discards them and blocks one cycle.
        CriqFull = 1'b1;
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("preFlushCount", {13'd0, StageCount}, 16'd3);
        CriqFull  = 1'b0;
        CriqClean = 1'b1;
        #1;
        checkOutput("flushSameWable", {15'd0, Wable}, 16'd0);
        tick();
        checkOutput("flushCount", {13'd0, StageCount}, 16'd0);
        checkOutput("flushWable", {15'd0, Wable}, 16'd0);
        checkOutput("flushReady", {15'd0, RetireReady}, 16'd0);
        CriqClean = 1'b0;
        tick();
        checkOutput("postFlushReady", {15'd0, RetireReady}, 16'd1);
        checkOutput("flushReclaim", ReclaimCnt, expRecl[15:0]);
        checkOutput("errSticky", {15'd0, ErrOverflow}, 16'd1);

        // Asynchronous reset mid-operation drops staged tags immediately.
        CriqFull = 1'b1;
        applyStimulus(1'b1, 5'd6, 1'b1, 5'd8, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("preRstCount", {13'd0, StageCount}, 16'd2);
        #2;
        Rest     = 1'b0;
        CriqFull = 1'b0;
        #1;
        checkOutput("asyncCount", {13'd0, StageCount}, 16'd0);
        checkOutput("asyncWable", {15'd0, Wable}, 16'd0);
        checkOutput("asyncReclaim", ReclaimCnt, 16'd0);
        checkOutput("asyncDin", {11'd0, Din}, 16'd0);
        checkOutput("asyncReady", {15'd0, RetireReady}, 16'd1);
        tick();
        #2;
        Rest = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("postRstReclaim", ReclaimCnt, 16'd0);
        checkOutput("postRstCount", {13'd0, StageCount}, 16'd0);

        checkOutput("queueEmpty", expQ.size() > 0 ? 16'd1 : 16'd0, 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/criq_reclaim.md
CRIQ_RECLAIM -- requirements
Module: criq_reclaim

Interface
REQ-001 The block SHALL have the parameter CRIQWIDE, default 5, meaning the physical tag width.
REQ-002 The block SHALL have the parameter STAGEDEEP, default 4, meaning the staging buffer depth.
REQ-003 Clk  input  1  single clock; every register is clocked on its rising edge.
REQ-004 Rest  input  1  reset, asynchronous and active-low.
REQ-005 RetireValid0  input  1  retire slot 0 releases an old physical tag.
REQ-006 RetireTag0  input  CRIQWIDE  tag released by slot 0.
REQ-007 RetireValid1  input  1  retire slot 1 releases an old physical tag.
REQ-008 RetireTag1  input  CRIQWIDE  tag released by slot 1.
REQ-009 RetireReady  output  1  the block can accept both slots in this cycle.
REQ-010 CriqClean  input  1  pipeline flush, the same signal that restores the free-list queue.
REQ-011 CriqFull  input  1  the free-list queue is full.
REQ-012 Wable  output  1  write strobe to the free-list queue.
REQ-013 Din  output  CRIQWIDE  tag written to the free-list queue.
REQ-014 StageCount  output  3  number of valid staging entries.
REQ-015 ReclaimCnt  output  16  number of free-list writes, wrapping at 16 bits.
REQ-016 ErrOverflow  output  1  sticky flag: a retire was offered while RetireReady was 0.

Function
REQ-017 The staging buffer SHALL be a circular FIFO of STAGEDEEP entries with 2-bit head/tail pointers that wrap 3->0; StageCount SHALL be a registered count of 0..4.
REQ-018 RetireReady SHALL be the combinational value (StageCount <= 2) && (state == RUN).
REQ-019 In a cycle where RetireReady=1, each slot with RetireValid=1 and a nonzero tag SHALL be pushed, slot 0 before slot 1.
REQ-020 Valid tag 0 SHALL be discarded and never pushed, because tag 0 is the architectural zero register.
REQ-021 A valid slot offered while RetireReady=0 SHALL be dropped and SHALL set ErrOverflow; ErrOverflow SHALL clear only on reset.
REQ-022 Wable SHALL be the combinational value (StageCount != 0) && !CriqFull && (state == RUN).
REQ-023 Din SHALL equal the head entry whenever StageCount != 0, and SHALL be 0 otherwise.
REQ-024 When Wable=1, the head entry SHALL be popped at that clock edge and ReclaimCnt SHALL increment.
REQ-025 Push and pop in the same cycle SHALL both take effect, with next StageCount = StageCount + pushes - pop.
REQ-026 Latency SHALL be one cycle minimum: a tag accepted in cycle N appears on Din no earlier than cycle N+1.
REQ-027 Tags SHALL leave the block in the order they were accepted.
REQ-028 The FSM SHALL have two states, RUN and FLUSH.
REQ-029 In RUN, CriqClean=1 SHALL move the FSM to FLUSH, empty the buffer (pointers 0, StageCount 0), suppress Wable and suppress pushes in that same cycle.
REQ-030 In FLUSH, Wable=0 and RetireReady=0; the FSM SHALL return to RUN the next cycle unless CriqClean is still 1, in which case it SHALL stay in FLUSH.
REQ-031 While CriqFull=1, the block SHALL hold the head entry and SHALL keep accepting retires until StageCount exceeds 2.

Reset
REQ-032 When Rest=0, the block SHALL asynchronously force: state RUN, pointers 0, StageCount 0, ReclaimCnt 0, ErrOverflow 0.
REQ-033 During reset, outputs SHALL be Wable=0, Din=0, RetireReady=1.
REQ-034 Reset asserted mid-operation SHALL discard all staged tags, with no Wable pulse emitted afterwards for them.

Verification
REQ-035 The bench SHALL cover: cycle 0 slot0=7, slot1=11, CriqFull=0 -> cycle 1 Wable=1, Din=7; cycle 2 Wable=1, Din=11; ReclaimCnt=2.
REQ-036 The bench SHALL cover: slot0 valid with tag 0 and slot1=5 -> only 5 staged, StageCount=1, one Wable pulse.
REQ-037 The bench SHALL cover: CriqFull=1 while offering pairs 3/7, then 9 -> StageCount=3, RetireReady=0; the next offer sets ErrOverflow=1; after CriqFull drops, Din=3, 7, 9 in order.
REQ-038 The bench SHALL cover: StageCount=3 plus CriqClean=1 -> next cycle StageCount=0, state FLUSH, Wable=0; the cycle after, RetireReady=1.
REQ-039 The bench SHALL cover: steady push of 2 per cycle with CriqFull=0 -> StageCount saturates at 2 or 3 with no drop and ErrOverflow=0.
REQ-040 The bench SHALL cover: Rest dropped asynchronously between clock edges with StageCount=2 -> StageCount=0, Wable=0 immediately, and ReclaimCnt=0.
